fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: PC_W, 16, program counter and instruction-address width.
REQ-002 Parameter: INSTR_W, 32, instruction width.
REQ-003 Parameter: TIMEOUT, 8, maximum cycles the unit waits for im_ack.
REQ-004 Port: clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 Port: rst_f  input  1  synchronous, active-high reset.
REQ-006 Port: ir_load  input  1  from ctrl; starts an instruction fetch at the current pc.
REQ-007 Port: pc_write  input  1  from ctrl; updates pc this cycle.
REQ-008 Port: pc_sel  input  1  from ctrl; 0 selects pc+1, 1 selects the branch target.
REQ-009 Port: br_sel  input  1  from ctrl; 1 selects an absolute target (imm), 0 a relative target (pc+imm).
REQ-010 Port: im_req  output  1  instruction-memory read request; held high until acknowledged.
REQ-011 Port: im_addr  output  PC_W  instruction-memory address; stable while im_req is high.
REQ-012 Port: im_rdata  input  INSTR_W  instruction-memory read data; valid when im_ack is high.
REQ-013 Port: im_ack  input  1  instruction-memory acknowledge; single-cycle pulse.
REQ-014 Port: ir  output  INSTR_W  instruction register.
REQ-015 Port: opcode  output  4  ir[31:28], to ctrl.
REQ-016 Port: mm  output  4  ir[27:24], condition/addressing field, to ctrl.
REQ-017 Port: imm  output  16  ir[15:0], branch offset or target.
REQ-018 Port: pc  output  PC_W  current program counter.
REQ-019 Port: fetch_busy  output  1  high while a fetch is outstanding; ctrl stalls on it.
REQ-020 Port: fetch_err  output  1  sticky flag; set when a fetch times out.

Function
REQ-021 The FSM SHALL have two states: IDLE and BUSY.
REQ-022 In IDLE, ir_load=1 SHALL latch im_addr<=pc, set im_req=1 and fetch_busy=1, and move the FSM to BUSY on the next edge.
REQ-023 In BUSY with im_ack=1, the unit SHALL load ir<=im_rdata, clear im_req and fetch_busy, and return to IDLE; the new ir is visible the cycle after the ack (latency ≥2 cycles from ir_load).
REQ-024 In BUSY, ir_load SHALL be ignored; im_addr and im_req SHALL stay unchanged until ack or timeout.
REQ-025 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack; on reaching TIMEOUT, the unit SHALL load ir with 0 (NOOP), set fetch_err, drop im_req, and return to IDLE.
REQ-026 im_ack while in IDLE SHALL be ignored (late or stray ack).
REQ-027 When pc_write=1, pc SHALL take pc+1 if pc_sel=0, imm if pc_sel=1 and br_sel=1, or pc+imm if pc_sel=1 and br_sel=0.
REQ-028 All pc arithmetic SHALL be modulo 2^PC_W (0xFFFF+1=0x0000); imm is unsigned.
REQ-029 pc_write SHALL take effect in any FSM state; the outstanding im_addr is unaffected.
REQ-030 When ir_load and pc_write are both 1 in IDLE, im_addr SHALL use the pre-update pc and pc SHALL advance in the same cycle.
REQ-031 The branch target SHALL use the imm held in ir at the time of pc_write.
REQ-032 opcode, mm, and imm SHALL be combinational slices of ir.

Reset
REQ-033 When rst_f=1 at a clock edge: pc=0, ir=0, im_addr=0, im_req=0, fetch_busy=0, fetch_err=0, wait counter=0, FSM=IDLE.
REQ-034 Reset during BUSY SHALL abandon the fetch; a subsequent ack SHALL be ignored per REQ-026.
REQ-035 rst_f SHALL take priority over all other inputs in the same cycle.

Structure
REQ-036 Opcode constants (NOOP=0, BRA=4, BRR=5, ALU_OP=8, HLT=15), the field bit positions, and the FSM state encoding SHALL live in a shared sisc package also used by ctrl.
REQ-037 The pc register and its next-pc mux SHALL be one sub-module, pc_unit; the FSM, IR, and counter stay in fetch_unit.

Verification
REQ-038 Reset, ir_load with pc=0, ack after 2 cycles with data 0x81230005 -> im_addr=0, ir=0x81230005, opcode=8, mm=1, imm=0x0005, fetch_busy low after ack.
REQ-039 pc=0x0010, ir.imm=0x0004, pc_write with pc_sel=1 and br_sel=0 -> pc=0x0014; repeat with br_sel=1 -> pc=0x0004.
REQ-040 pc=0xFFFF, pc_write with pc_sel=0 -> pc=0x0000.
REQ-041 ir_load with no ack for 8 cycles -> ir=0, fetch_err=1, im_req=0, state IDLE; a later ack -> no change to ir.
REQ-042 ir_load and pc_write together at pc=0x0007 -> im_addr=0x0007 and pc=0x0008; a second ir_load while BUSY -> im_addr stays 0x0007.
REQ-043 rst_f=1 during BUSY, then ack -> all outputs return to reset values, ir remains 0.

Source files
------------

// File: rtl/sisc_pkg.sv
// sisc_pkg: definitions shared by the fetch unit and the control unit.
//   - opcode_e      : instruction opcodes carried in ir[31:28]
//   - field bounds  : bit positions of the opcode, mm and imm fields
//   - fetch_state_e : encoding of the fetch FSM states
package sisc_pkg;

  typedef enum logic [3:0] {
    OP_NOOP = 4'd0,
    OP_BRA  = 4'd4,
    OP_BRR  = 4'd5,
    OP_ALU  = 4'd8,
    OP_HLT  = 4'd15
  } opcode_e;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int MM_MSB     = 27;
  localparam int MM_LSB     = 24;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;
  localparam int IMM_W      = IMM_MSB - IMM_LSB + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/pc_unit.sv
// pc_unit: program counter register with its next-pc selection.
// Ports:
//   clk, rst_f   : clock, synchronous active-high reset
//   pc_write     : update pc this cycle
//   pc_sel       : 0 = pc+1, 1 = branch target
//   br_sel       : 1 = absolute target (imm), 0 = relative target (pc+imm)
//   imm          : unsigned branch offset/target taken from the current ir
//   pc           : current program counter
module pc_unit
  import sisc_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic             clk,
  input  logic             rst_f,
  input  logic             pc_write,
  input  logic             pc_sel,
  input  logic             br_sel,
  input  logic [IMM_W-1:0] imm,
  output logic [PC_W-1:0]  pc
);

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic [PC_W-1:0] imm_ext;

  // imm is unsigned, so it is zero-extended (or truncated) to pc width;
  // all sums simply wrap at 2^PC_W.
  assign imm_ext = PC_W'(imm);

  always_comb begin
    pc_d = pc_q;
    if (pc_write) begin
      if (!pc_sel) begin
        pc_d = pc_q + PC_W'(1);
      end else if (br_sel) begin
        pc_d = imm_ext;
      end else begin
        pc_d = pc_q + imm_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      pc_q <= '0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction fetch FSM, instruction register and timeout counter.
// Ports:
//   clk, rst_f          : clock, synchronous active-high reset
//   ir_load             : start a fetch at the current pc (ignored while busy)
//   pc_write/pc_sel/br_sel : pc update controls, forwarded to pc_unit
//   im_req/im_addr      : instruction memory request and address (held until ack/timeout)
//   im_rdata/im_ack     : instruction memory data and single-cycle acknowledge
//   ir, opcode, mm, imm : instruction register and its decoded fields
//   pc                  : current program counter
//   fetch_busy          : a fetch is outstanding
//   fetch_err           : sticky, set when a fetch times out
module fetch_unit
  import sisc_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               ir_load,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  output logic               im_req,
  output logic [PC_W-1:0]    im_addr,
  input  logic [INSTR_W-1:0] im_rdata,
  input  logic               im_ack,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [IMM_W-1:0]   imm,
  output logic [PC_W-1:0]    pc,
  output logic               fetch_busy,
  output logic               fetch_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

  fetch_state_e       state_q, state_d;
  logic               im_req_q, im_req_d;
  logic [PC_W-1:0]    im_addr_q, im_addr_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic               fetch_err_q, fetch_err_d;

  // The wait counter holds the number of ack-less BUSY cycles already seen,
  // so a fetch gives up at the end of its TIMEOUT-th BUSY cycle. An ack in
  // that same cycle still wins over the timeout.
  always_comb begin
    state_d     = state_q;
    im_req_d    = im_req_q;
    im_addr_d   = im_addr_q;
    ir_d        = ir_q;
    wait_cnt_d  = wait_cnt_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      ST_IDLE: begin
        if (ir_load) begin
          state_d    = ST_BUSY;
          im_req_d   = 1'b1;
          im_addr_d  = pc;
          wait_cnt_d = '0;
        end
      end
      ST_BUSY: begin
        if (im_ack) begin
          state_d  = ST_IDLE;
          im_req_d = 1'b0;
          ir_d     = im_rdata;
        end else if (wait_cnt_q == LAST_WAIT) begin
          // Timed out: substitute a NOOP (all-zero instruction).
          state_d     = ST_IDLE;
          im_req_d    = 1'b0;
          ir_d        = '0;
          fetch_err_d = 1'b1;
          wait_cnt_d  = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_f) begin
      state_q     <= ST_IDLE;
      im_req_q    <= 1'b0;
      im_addr_q   <= '0;
      ir_q        <= '0;
      wait_cnt_q  <= '0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      im_req_q    <= im_req_d;
      im_addr_q   <= im_addr_d;
      ir_q        <= ir_d;
      wait_cnt_q  <= wait_cnt_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  // Branch targets always use the imm of the instruction currently in ir.
  pc_unit #(
    .PC_W(PC_W)
  ) u_pc_unit (
    .clk     (clk),
    .rst_f   (rst_f),
    .pc_write(pc_write),
    .pc_sel  (pc_sel),
    .br_sel  (br_sel),
    .imm     (imm),
    .pc      (pc)
  );

  assign im_req     = im_req_q;
  assign im_addr    = im_addr_q;
  assign ir         = ir_q;
  assign opcode     = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign mm         = ir_q[MM_MSB:MM_LSB];
  assign imm        = ir_q[IMM_MSB:IMM_LSB];
  assign fetch_busy = (state_q == ST_BUSY);
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
module tb_fetch_unit;

  logic        clk;
  logic        rst_f;
  logic        ir_load;
  logic        pc_write;
  logic        pc_sel;
  logic        br_sel;
  logic        im_req;
  logic [15:0] im_addr;
  logic [31:0] im_rdata;
  logic        im_ack;
  logic [31:0] ir;
  logic [3:0]  opcode;
  logic [3:0]  mm;
  logic [15:0] imm;
  logic [15:0] pc;
  logic        fetch_busy;
  logic        fetch_err;

  int checks;
  int errors;

  // Expected ir values, pushed when a fetch is launched and popped when it completes.
  logic [31:0] exp_ir_q[$];

  typedef struct {
    logic [31:0] ir_data;
    int          ack_delay;
    logic        sel;
    logic        br;
    logic [15:0] exp_pc;
  } vec_t;

  vec_t vecs[8];

  fetch_unit #(
    .PC_W(16),
    .INSTR_W(32),
    .TIMEOUT(8)
  ) dut (
    .clk       (clk),
    .rst_f     (rst_f),
    .ir_load   (ir_load),
    .pc_write  (pc_write),
    .pc_sel    (pc_sel),
    .br_sel    (br_sel),
    .im_req    (im_req),
    .im_addr   (im_addr),
    .im_rdata  (im_rdata),
    .im_ack    (im_ack),
    .ir        (ir),
    .opcode    (opcode),
    .mm        (mm),
    .imm       (imm),
    .pc        (pc),
    .fetch_busy(fetch_busy),
    .fetch_err (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock; outputs are sampled and inputs driven 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pc"}, 32'(pc), 32'h0);
    checkOutput({tag, "_ir"}, ir, 32'h0);
    checkOutput({tag, "_im_addr"}, 32'(im_addr), 32'h0);
    checkOutput({tag, "_im_req"}, 32'(im_req), 32'h0);
    checkOutput({tag, "_busy"}, 32'(fetch_busy), 32'h0);
    checkOutput({tag, "_err"}, 32'(fetch_err), 32'h0);
  endtask

  // Launch a fetch, ack it after ack_delay extra BUSY cycles, then compare ir.
  task automatic doFetch(input logic [31:0] data, input int ack_delay, input logic [15:0] exp_addr);
    logic [31:0] exp_ir;
    exp_ir_q.push_back(data);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    checkOutput("fetch_im_addr", 32'(im_addr), 32'(exp_addr));
    checkOutput("fetch_im_req", 32'(im_req), 32'h1);
    checkOutput("fetch_busy_set", 32'(fetch_busy), 32'h1);
    repeat (ack_delay) tick();
    im_ack   = 1'b1;
    im_rdata = data;
    tick();
    im_ack   = 1'b0;
    im_rdata = $urandom;
    exp_ir = exp_ir_q.pop_front();
    checkOutput("fetch_ir", ir, exp_ir);
    checkOutput("fetch_busy_clr", 32'(fetch_busy), 32'h0);
    checkOutput("fetch_im_req_clr", 32'(im_req), 32'h0);
  endtask

  task automatic applyStimulus(input vec_t v, input logic [15:0] cur_pc);
    doFetch(v.ir_data, v.ack_delay, cur_pc);
    pc_write = 1'b1;
    pc_sel   = v.sel;
    br_sel   = v.br;
    tick();
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
  endtask

  initial begin
    logic [15:0] exp_pc;
    logic [31:0] exp_ir;
    int          busy_cycles;

    checks   = 0;
    errors   = 0;
    rst_f    = 1'b1;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    pc_sel   = 1'b0;
    br_sel   = 1'b0;
    im_ack   = 1'b0;
    im_rdata = '0;

    vecs[0] = '{32'h40000010, 0, 1'b1, 1'b1, 16'h0010};
    vecs[1] = '{32'h50000004, 1, 1'b1, 1'b0, 16'h0014};
    vecs[2] = '{32'h50000004, 2, 1'b1, 1'b1, 16'h0004};
    vecs[3] = '{32'h4000FFFF, 3, 1'b1, 1'b1, 16'hFFFF};
    vecs[4] = '{32'h80000000, 7, 1'b0, 1'b0, 16'h0000};
    vecs[5] = '{32'h8F0F1234, 0, 1'b0, 1'b1, 16'h0001};
    vecs[6] = '{32'h5000FFFF, 4, 1'b1, 1'b0, 16'h0000};
    vecs[7] = '{32'h40000007, 1, 1'b1, 1'b1, 16'h0007};

    tick();
    tick();
    rst_f = 1'b0;
    checkResetState("reset");

    // A stray ack in IDLE must not touch ir.
    im_ack   = 1'b1;
    im_rdata = 32'hCAFEF00D;
    tick();
    im_ack = 1'b0;
    checkOutput("stray_ack_ir", ir, 32'h0);
    checkOutput("stray_ack_busy", 32'(fetch_busy), 32'h0);

    // Basic fetch at pc 0 with the ack in the second BUSY cycle.
    doFetch(32'h81230005, 1, 16'h0000);
    checkOutput("decode_opcode", 32'(opcode), 32'h8);
    checkOutput("decode_mm", 32'(mm), 32'h1);
    checkOutput("decode_imm", 32'(imm), 32'h0005);
    checkOutput("fetch_no_pc_change", 32'(pc), 32'h0);

    // Table of fetch + pc_write steps, each checked against hand-derived pc.
    exp_pc = 16'h0000;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], exp_pc);
      exp_pc = vecs[i].exp_pc;
      checkOutput($sformatf("vec%0d_pc", i), 32'(pc), 32'(exp_pc));
    end

    // ir_load and pc_write together: im_addr uses the old pc, pc advances.
    exp_ir_q.push_back(32'h8ABC0123);
    ir_load  = 1'b1;
    pc_write = 1'b1;
    tick();
    checkOutput("combo_im_addr", 32'(im_addr), 32'h0007);
    checkOutput("combo_pc", 32'(pc), 32'h0008);
    checkOutput("combo_busy", 32'(fetch_busy), 32'h1);
    // Second ir_load while BUSY is ignored; pc_write still applies.
    tick();
    ir_load  = 1'b0;
    pc_write = 1'b0;
    checkOutput("busy_reload_im_addr", 32'(im_addr), 32'h0007);
    checkOutput("busy_reload_im_req", 32'(im_req), 32'h1);
    checkOutput("busy_pc_write", 32'(pc), 32'h0009);
    im_ack   = 1'b1;
    im_rdata = 32'h8ABC0123;
    tick();
    im_ack = 1'b0;
    exp_ir = exp_ir_q.pop_front();
    checkOutput("combo_ir", ir, exp_ir);
    checkOutput("combo_err_clear", 32'(fetch_err), 32'h0);

    // Timeout: no ack for 8 BUSY cycles yields a NOOP and a sticky error.
    exp_ir_q.push_back(32'h0);
    ir_load = 1'b1;
    tick();
    ir_load = 1'b0;
    busy_cycles = 1;
    while (fetch_busy === 1'b1 && busy_cycles < 20) begin
      tick();
      if (fetch_busy === 1'b1) busy_cycles++;
    end
    checkOutput("timeout_busy_cycles", 32'(busy_cycles), 32'd8);
    exp_ir = exp_ir_q.pop_front();
    checkOutput("timeout_ir", ir, exp_ir);
    checkOutput("timeout_err", 32'(fetch_err), 32'h1);
    checkOutput("timeout_im_req", 32'(im_req), 32'h0);
    im_ack   = 1'b1;
    im_rdata = 32'hDEADBEEF;
    tick();
    im_ack = 1'b0;
    checkOutput("late_ack_ir", ir, 32'h0);
    checkOutput("late_ack_busy", 32'(fetch_busy), 32'h0);

    // fetch_err stays set across a later successful fetch.
    doFetch(32'hF0000000, 2, 16'h0009);
    checkOutput("err_sticky", 32'(fetch_err), 32'h1);
    checkOutput("hlt_opcode", 32'(opcode), 32'hF);

    // Reset during BUSY (with competing inputs) abandons the fetch; the later ack is ignored.
    ir_load = 1'b1;
    tick();
    checkOutput("pre_reset_busy", 32'(fetch_busy), 32'h1);
    rst_f    = 1'b1;
    pc_write = 1'b1;
    pc_sel   = 1'b0;
    tick();
    rst_f    = 1'b0;
    ir_load  = 1'b0;
    pc_write = 1'b0;
    im_ack   = 1'b1;
    im_rdata = 32'h12345678;
    tick();
    im_ack = 1'b0;
    checkResetState("busy_reset");

    checkOutput("scoreboard_empty", 32'(exp_ir_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time limit so the bench always ends even if something stalls.
  initial begin
    #20000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
